// File: rtl/cla_pipe_adder_if.sv
// Valid/ready operand and result bundle for cla_pipe_adder.
// The producer/consumer side uses master; the adder itself uses slave.
interface cla_pipe_adder_if #(
  parameter int WIDTH = 16
);
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             cin;
  logic             sub;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] sum;
  logic             cout;
  logic             overflow;
  logic             zero;

  modport master (
    output in_valid, a, b, cin, sub, out_ready,
    input  in_ready, out_valid, sum, cout, overflow, zero
  );

  modport slave (
    input  in_valid, a, b, cin, sub, out_ready,
    output in_ready, out_valid, sum, cout, overflow, zero
  );
endinterface

// File: rtl/cla_pipe_adder.sv
// Pipelined carry-lookahead adder/subtractor: one GROUP-bit lookahead group per stage,
// group carry registered between stages, whole pipe stalls together under backpressure.
module cla_pipe_adder #(
  parameter int WIDTH = 16,
  parameter int GROUP = 4
) (
  input logic             clock,
  input logic             reset,
  cla_pipe_adder_if.slave bus
);
  localparam int NG = WIDTH / GROUP;
  localparam logic [WIDTH-1:0] GMASK = WIDTH'({GROUP{1'b1}});

  // Full lookahead inside one group: every carry is a flat sum of generate/propagate terms.
  function automatic logic [GROUP:0] cla_group(input logic [GROUP-1:0] x,
                                               input logic [GROUP-1:0] y,
                                               input logic             c0);
    logic [GROUP-1:0] p;
    logic [GROUP-1:0] g;
    logic [GROUP:0]   c;
    logic             t;
    p    = x ^ y;
    g    = x & y;
    c    = {(GROUP+1){1'b0}};
    c[0] = c0;
    for (int i = 0; i < GROUP; i++) begin
      t = c0;
      for (int j = 0; j <= i; j++) t = t & p[j];
      c[i+1] = t;
      for (int j = 0; j <= i; j++) begin
        t = g[j];
        for (int k = j + 1; k <= i; k++) t = t & p[k];
        c[i+1] = c[i+1] | t;
      end
    end
    return {c[GROUP], p ^ c[GROUP-1:0]};
  endfunction

  logic                 adv_s;
  logic [NG-1:0]        vld_r;
  logic [NG-1:0]        cry_r;
  logic [WIDTH-1:0]     opa_r  [NG];
  logic [WIDTH-1:0]     opb_r  [NG];
  logic [WIDTH-1:0]     sum_r  [NG];
  logic                 sa_r   [NG];
  logic                 sb_r   [NG];
  logic                 ovf_r;
  logic                 zero_r;

  logic [WIDTH-1:0]     opa_s  [NG];
  logic [WIDTH-1:0]     opb_s  [NG];
  logic [WIDTH-1:0]     sumi_s [NG];
  logic [WIDTH-1:0]     sumo_s [NG];
  logic                 ci_s   [NG];
  logic                 sa_s   [NG];
  logic                 sb_s   [NG];
  logic [GROUP:0]       grp_s  [NG];
  logic                 ovf_s;
  logic                 zero_s;

  // Stage 0 folds subtract into inverted b and inverted carry-in; later stages read the previous registers.
  for (genvar k = 0; k < NG; k++) begin : g_stage
    if (k == 0) begin : g_src
      assign opa_s[k]  = bus.a;
      assign opb_s[k]  = bus.sub ? ~bus.b : bus.b;
      assign ci_s[k]   = bus.sub ^ bus.cin;
      assign sumi_s[k] = {WIDTH{1'b0}};
      assign sa_s[k]   = bus.a[WIDTH-1];
      assign sb_s[k]   = opb_s[k][WIDTH-1];
    end else begin : g_src
      assign opa_s[k]  = opa_r[k-1];
      assign opb_s[k]  = opb_r[k-1];
      assign ci_s[k]   = cry_r[k-1];
      assign sumi_s[k] = sum_r[k-1];
      assign sa_s[k]   = sa_r[k-1];
      assign sb_s[k]   = sb_r[k-1];
    end
    assign grp_s[k]  = cla_group(opa_s[k][k*GROUP +: GROUP], opb_s[k][k*GROUP +: GROUP], ci_s[k]);
    assign sumo_s[k] = (sumi_s[k] & ~(GMASK << (k*GROUP)))
                     | (WIDTH'(grp_s[k][GROUP-1:0]) << (k*GROUP));
  end

  // Flags are resolved as the last group lands so they are registered with the sum.
  always_comb begin
    zero_s = ~|sumo_s[NG-1];
    ovf_s  = (sa_s[NG-1] == sb_s[NG-1]) & (sumo_s[NG-1][WIDTH-1] != sa_s[NG-1]);
  end

  assign adv_s        = ~vld_r[NG-1] | bus.out_ready;
  assign bus.in_ready = adv_s;

  // Pipeline registers: everything shifts one stage on advance and holds otherwise.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      vld_r  <= {NG{1'b0}};
      cry_r  <= {NG{1'b0}};
      ovf_r  <= 1'b0;
      zero_r <= 1'b0;
      for (int k = 0; k < NG; k++) begin
        opa_r[k] <= {WIDTH{1'b0}};
        opb_r[k] <= {WIDTH{1'b0}};
        sum_r[k] <= {WIDTH{1'b0}};
        sa_r[k]  <= 1'b0;
        sb_r[k]  <= 1'b0;
      end
    end else if (adv_s) begin
      vld_r[0] <= bus.in_valid;
      for (int k = 1; k < NG; k++) vld_r[k] <= vld_r[k-1];
      for (int k = 0; k < NG; k++) begin
        opa_r[k] <= opa_s[k];
        opb_r[k] <= opb_s[k];
        sum_r[k] <= sumo_s[k];
        cry_r[k] <= grp_s[k][GROUP];
        sa_r[k]  <= sa_s[k];
        sb_r[k]  <= sb_s[k];
      end
      ovf_r  <= ovf_s;
      zero_r <= zero_s;
    end
  end

  assign bus.out_valid = vld_r[NG-1];
  assign bus.sum       = sum_r[NG-1];
  assign bus.cout      = cry_r[NG-1];
  assign bus.overflow  = ovf_r;
  assign bus.zero      = zero_r;
endmodule

// File: tb/tb_cla_pipe_adder.sv
// Directed checks of cla_pipe_adder at 16/4 plus streaming/backpressure runs over several widths.
module tb_cla_pipe_adder;
  logic clock    = 1'b0;
  logic reset    = 1'b0;
  logic sweep_go = 1'b0;
  int   n_checks = 0;
  int   n_err    = 0;
  int   done_cnt = 0;

  always #5 clock = ~clock;

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  cla_pipe_adder_if #(.WIDTH(16)) bus();
  cla_pipe_adder #(.WIDTH(16), .GROUP(4)) dut (.clock(clock), .reset(reset), .bus(bus.slave));

  typedef struct {
    logic [15:0] a;
    logic [15:0] b;
    logic        cin;
    logic        sub;
    logic [15:0] s;
    logic        co;
    logic        ov;
    logic        z;
  } vec_t;

  vec_t dir_v [7] = '{
    '{16'hFFFF, 16'h0001, 1'b0, 1'b0, 16'h0000, 1'b1, 1'b0, 1'b1},
    '{16'h7FFF, 16'h0001, 1'b0, 1'b0, 16'h8000, 1'b0, 1'b1, 1'b0},
    '{16'h8000, 16'h0001, 1'b0, 1'b1, 16'h7FFF, 1'b1, 1'b1, 1'b0},
    '{16'h0003, 16'h0005, 1'b1, 1'b1, 16'hFFFD, 1'b0, 1'b0, 1'b0},
    '{16'h1234, 16'h4321, 1'b1, 1'b0, 16'h5556, 1'b0, 1'b0, 1'b0},
    '{16'h5A5A, 16'h5A5A, 1'b0, 1'b1, 16'h0000, 1'b1, 1'b0, 1'b1},
    '{16'h8000, 16'h8000, 1'b0, 1'b0, 16'h0000, 1'b1, 1'b1, 1'b1}
  };

  initial begin
    int lat;
    int pulses;
    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b1;
    bus.a         = 16'h0000;
    bus.b         = 16'h0000;
    bus.cin       = 1'b0;
    bus.sub       = 1'b0;
    #1 reset = 1'b1;
    #1;
    check_eq("rst_out_valid", 64'(bus.out_valid), 64'd0);
    check_eq("rst_in_ready",  64'(bus.in_ready),  64'd1);
    check_eq("rst_sum",       64'(bus.sum),       64'd0);
    check_eq("rst_cout",      64'(bus.cout),      64'd0);
    check_eq("rst_overflow",  64'(bus.overflow),  64'd0);
    check_eq("rst_zero",      64'(bus.zero),      64'd0);
    @(negedge clock);
    @(negedge clock);
    reset = 1'b0;
    @(negedge clock);

    // One transaction at a time: latency is four negedges after the drive.
    for (int i = 0; i < 7; i++) begin
      bus.a = dir_v[i].a; bus.b = dir_v[i].b; bus.cin = dir_v[i].cin; bus.sub = dir_v[i].sub;
      bus.in_valid = 1'b1;
      @(negedge clock);
      bus.in_valid = 1'b0;
      lat = 1;
      while (bus.out_valid !== 1'b1 && lat < 20) begin
        @(negedge clock);
        lat++;
      end
      check_eq($sformatf("v%0d_latency", i),  64'(lat),          64'd4);
      check_eq($sformatf("v%0d_sum", i),      64'(bus.sum),      64'(dir_v[i].s));
      check_eq($sformatf("v%0d_cout", i),     64'(bus.cout),     64'(dir_v[i].co));
      check_eq($sformatf("v%0d_overflow", i), 64'(bus.overflow), 64'(dir_v[i].ov));
      check_eq($sformatf("v%0d_zero", i),     64'(bus.zero),     64'(dir_v[i].z));
    end

    // Reset with transactions in flight.
    for (int i = 0; i < 3; i++) begin
      bus.a = 16'(i + 1); bus.b = 16'h0100; bus.cin = 1'b0; bus.sub = 1'b0;
      bus.in_valid = 1'b1;
      @(negedge clock);
    end
    bus.in_valid = 1'b0;
    @(negedge clock);
    check_eq("pre_rst_valid", 64'(bus.out_valid), 64'd1);
    #2 reset = 1'b1;
    #1;
    check_eq("mid_rst_out_valid", 64'(bus.out_valid), 64'd0);
    check_eq("mid_rst_in_ready",  64'(bus.in_ready),  64'd1);
    check_eq("mid_rst_sum",       64'(bus.sum),       64'd0);
    @(negedge clock);
    reset = 1'b0;
    pulses = 0;
    repeat (8) begin
      @(negedge clock);
      if (bus.out_valid !== 1'b0) pulses++;
    end
    check_eq("post_rst_pulses", 64'(pulses), 64'd0);

    sweep_go = 1'b1;
    for (int k = 0; k < 3000 && done_cnt < 5; k++) @(negedge clock);
    check_eq("sweep_done", 64'(done_cnt), 64'd5);

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

  // Streaming against a reference model for each (WIDTH, GROUP); config 0 also stalls the pipe.
  for (genvar gi = 0; gi < 5; gi++) begin : g_sw
    localparam int W     = (gi == 0) ? 16 : (gi == 1) ? 8 : (gi == 2) ? 32 : (gi == 3) ? 32 : 4;
    localparam int G     = (gi == 3) ? 8 : 4;
    localparam int NGS   = W / G;
    localparam bit STALL = (gi == 0);
    localparam int N     = 20;

    cla_pipe_adder_if #(.WIDTH(W)) sbus();
    cla_pipe_adder #(.WIDTH(W), .GROUP(G)) sdut (.clock(clock), .reset(reset), .bus(sbus.slave));

    function automatic logic [W+2:0] model(input logic [W-1:0] x, input logic [W-1:0] y,
                                           input logic ci, input logic s);
      logic [W-1:0] ye;
      logic [W:0]   r;
      logic         ov;
      ye = s ? ~y : y;
      r  = {1'b0, x} + {1'b0, ye} + {{W{1'b0}}, (s ? ~ci : ci)};
      ov = (x[W-1] == ye[W-1]) && (r[W-1] != x[W-1]);
      return {ov, (r[W-1:0] == {W{1'b0}}), r[W], r[W-1:0]};
    endfunction

    initial begin
      logic [W-1:0] va [N];
      logic [W-1:0] vb [N];
      logic         vc [N];
      logic         vs [N];
      logic [W+2:0] expq [$];
      logic [W+2:0] snap;
      logic [W+2:0] obs;
      logic         stalled;
      int sent, got, cyc, drops, acc0, first_out;
      sbus.in_valid  = 1'b0;
      sbus.out_ready = 1'b1;
      sbus.a         = {W{1'b0}};
      sbus.b         = {W{1'b0}};
      sbus.cin       = 1'b0;
      sbus.sub       = 1'b0;
      snap           = {(W+3){1'b0}};
      for (int i = 0; i < N; i++) begin
        va[i] = W'({$urandom(), $urandom()});
        vb[i] = W'({$urandom(), $urandom()});
        vc[i] = 1'($urandom());
        vs[i] = 1'($urandom());
      end
      va[0] = {W{1'b1}}; vb[0] = {{(W-1){1'b0}}, 1'b1}; vc[0] = 1'b0; vs[0] = 1'b0;
      wait (sweep_go === 1'b1);
      sent = 0; got = 0; cyc = 0; drops = 0; acc0 = -1; first_out = -1;
      while (got < N && cyc < 400) begin
        @(negedge clock);
        cyc++;
        stalled = STALL && cyc >= 8 && cyc < 11;
        sbus.out_ready = ~stalled;
        obs = {sbus.overflow, sbus.zero, sbus.cout, sbus.sum};
        if (sbus.out_valid === 1'b1) begin
          if (first_out < 0) first_out = cyc;
          if (stalled) begin
            if (cyc == 8) snap = obs;
            else check_eq($sformatf("cfg%0d_hold", gi), 64'(obs), 64'(snap));
          end else begin
            check_eq($sformatf("cfg%0d_expected_pending", gi), 64'(expq.size() != 0), 64'd1);
            if (expq.size() != 0) check_eq($sformatf("cfg%0d_res%0d", gi, got), 64'(obs), 64'(expq.pop_front()));
            got++;
          end
        end
        if (sent < N) begin
          sbus.a = va[sent]; sbus.b = vb[sent]; sbus.cin = vc[sent]; sbus.sub = vs[sent];
          sbus.in_valid = 1'b1;
        end else begin
          sbus.in_valid = 1'b0;
        end
        #1;
        if (stalled) check_eq($sformatf("cfg%0d_stall_in_ready", gi), 64'(sbus.in_ready), 64'd0);
        else if (sbus.in_ready !== 1'b1) drops++;
        if (sbus.in_valid && sbus.in_ready) begin
          expq.push_back(model(va[sent], vb[sent], vc[sent], vs[sent]));
          if (acc0 < 0) acc0 = cyc;
          sent++;
        end
      end
      sbus.in_valid = 1'b0;
      check_eq($sformatf("cfg%0d_count", gi),    64'(got),              64'(N));
      check_eq($sformatf("cfg%0d_leftover", gi), 64'(expq.size()),      64'd0);
      check_eq($sformatf("cfg%0d_drops", gi),    64'(drops),            64'd0);
      check_eq($sformatf("cfg%0d_latency", gi),  64'(first_out - acc0), 64'(NGS));
      done_cnt++;
    end
  end
endmodule

// File: doc/cla_pipe_adder.md
# cla_pipe_adder

Parameterised, pipelined carry-lookahead adder/subtractor with a valid/ready handshake on both sides. The WIDTH-bit operation is split into GROUP-bit carry-lookahead groups. Each pipeline stage resolves one group, and the group carry-out is registered into the next stage. This sustains one operation per clock at any WIDTH without a long ripple path. It is the datapath arithmetic unit that sits between operand-producing blocks (register file, accumulator) and result consumers that may apply backpressure.

## Interface
- WIDTH, 16: operand and result width in bits. Must be a multiple of GROUP and at least GROUP.
- GROUP, 4: bits per carry-lookahead group. Group carries use full lookahead: c[i+1] = g[i] | p[i]&c[i] expanded, with p = a^b and g = a&b.
- NG (localparam): WIDTH/GROUP. This is the number of group stages and equals the latency in cycles.

Ports:
- clock  in  1  single clock; all state updates on the rising edge.
- reset  in  1  asynchronous, active-high reset.
- in_valid  in  1  operands present.
- in_ready  out  1  block can accept this cycle.
- a  in  WIDTH  operand A.
- b  in  WIDTH  operand B.
- cin  in  1  carry-in (add) or borrow-in (subtract).
- sub  in  1  0: a+b+cin; 1: a-b-cin.
- out_valid  out  1  result present.
- out_ready  in  1  consumer accepts this cycle.
- sum  out  WIDTH  result modulo 2^WIDTH.
- cout  out  1  carry-out (add) or not-borrow (subtract).
- overflow  out  1  two's-complement signed overflow.
- zero  out  1  sum == 0.

## Operation
- Effective operands:
  - b_eff = sub ? ~b : b.
  - c_eff = sub ? ~cin : cin.
  - The block computes a + b_eff + c_eff.
  - Subtract therefore gives a - b - cin, with cout=1 meaning no borrow.
- Pipeline stages:
  - The pipeline has NG stages. Each stage holds a valid bit, remaining operand bits, completed sum bits, the running carry, and the captured sign bits of a and b_eff.
  - Stage k (k = 0..NG-1) computes group k (bits k*GROUP .. k*GROUP+GROUP-1) from its operand slice and the incoming carry, using lookahead inside the group.
  - Stage 0 takes operands from the ports. Stage k>0 takes them from the stage k-1 registers.
- Flags are computed at the final stage:
  - cout = carry out of group NG-1.
  - overflow = (a[MSB]==b_eff[MSB]) & (sum[MSB]!=a[MSB]).
  - zero = ~|sum.
- Flow control:
  - The pipeline advances as a whole.
  - advance = ~out_valid | out_ready.
  - in_ready = advance.
  - When advance=0, every stage register, including the valid bits, holds its value.
  - Bubbles are not compressed.
- Transfer rules:
  - A transaction is accepted on an edge where in_valid & in_ready.
  - On an advance edge with in_valid=0, a bubble (valid=0) enters stage 0.
  - A result is consumed on an edge where out_valid & out_ready.
  - Results leave in acceptance order.
- Output stability:
  - While out_valid=1 and out_ready=0, sum, cout, overflow and zero hold stable.
  - When out_valid=0, the output values are don't-care.

## Timing
- Reset:
  - While reset is high, all valid bits clear asynchronously.
  - out_valid, sum, cout, overflow and zero all read 0.
  - in_ready=1, since out_valid=0.
  - Data registers may also clear to 0. Outputs must read 0 during reset.
- Reset mid-operation: all in-flight transactions are discarded, and no stale result appears after reset deasserts.
- Latency: a transaction accepted on edge E appears with out_valid=1 immediately after edge E+NG-1, provided no stall occurs. Each stalled cycle adds one cycle.
- Throughput: one result per cycle when out_ready is held at 1.
- Simultaneous consume and accept on the same edge are both allowed. A full pipe with out_ready=1 accepts every cycle.
- No combinational path from a, b, cin or sub to any output. The only combinational path is out_ready -> in_ready.

## Test plan
- Reset:
  - Stimulus: assert reset mid-cycle with three transactions in flight, then release.
  - Required: out_valid falls to 0 immediately without waiting for a clock, and in_ready=1. No out_valid pulse occurs in the following 8 cycles while in_valid=0.
- Carry across all groups:
  - Stimulus (WIDTH=16, GROUP=4): a=0xFFFF, b=0x0001, cin=0, sub=0, accepted on edge E.
  - Required: out_valid rises after edge E+3 with sum=0x0000, cout=1, zero=1, overflow=0.
- Signed overflow:
  - Case 1: a=0x7FFF, b=0x0001, sub=0 -> sum=0x8000, cout=0, overflow=1.
  - Case 2: a=0x8000, b=0x0001, sub=1, cin=0 -> sum=0x7FFF, cout=1, overflow=1.
  - Case 3: a=0x0003, b=0x0005, sub=1, cin=1 -> sum=0xFFFD, cout=0, overflow=0.
- Streaming:
  - Stimulus: 20 back-to-back random transactions with out_ready=1.
  - Required: one result per cycle in order, all matching a reference model, and in_ready never drops.
- Backpressure:
  - Stimulus: fill the pipe, then hold out_ready=0 for 3 cycles while in_valid=1.
  - Required: in_ready=0 and the outputs are held stable during the stall. No transaction is lost or duplicated after out_ready returns.
- Parameter sweep: repeat the streaming test for (WIDTH, GROUP) = (8,4), (32,4), (32,8) and (4,4). For (4,4), latency is 1 cycle.
